stream_credit_arb: RTL

STREAM_CREDIT_ARB -- requirements
Module: stream_credit_arb

---
 rtl/stream_credit_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/stream_credit_arb.sv
// Credit-gated round-robin stream arbiter: whole packets from NUM_SRC sources
// are merged onto one registered output, one beat per cycle while credits last.
module stream_credit_arb #(
  parameter int NUM_SRC  = 4,
  parameter int DATA_W   = 32,
  parameter int MAX_CRED = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         in_valid,
  input  logic [NUM_SRC-1:0]         in_last,
  input  logic [NUM_SRC*DATA_W-1:0]  in_data,
  output logic [NUM_SRC-1:0]         in_ready,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_SRC)-1:0] out_src,
  input  logic                       cred_return,
  output logic [3:0]                 cred_avail,
  output logic                       cred_err
);

  localparam int SRC_W = $clog2(NUM_SRC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SRC_W-1:0]   r_owner;
  logic [SRC_W-1:0]   w_owner_nxt;
  logic [SRC_W-1:0]   r_rr_ptr;
  logic [SRC_W-1:0]   w_rr_nxt;
  logic [3:0]         r_cred;
  logic               r_cred_err;
  logic               r_out_valid;
  logic               r_out_last;
  logic [DATA_W-1:0]  r_out_data;
  logic [SRC_W-1:0]   r_out_src;

  logic               w_found;
  logic [SRC_W-1:0]   w_pick;
  logic [SRC_W-1:0]   w_sel;
  logic [SRC_W-1:0]   w_sel_inc;
  logic               w_sel_last;
  logic               w_has_cred;
  logic               w_xfer;
  logic [NUM_SRC-1:0] w_ready;

  function automatic logic [SRC_W-1:0] wrap_idx(input int base, input int ofs);
    return SRC_W'((base + ofs) % NUM_SRC);
  endfunction

  assign w_has_cred = (r_cred != 4'd0);
  assign w_sel      = (r_state == ST_LOCK) ? r_owner : w_pick;
  assign w_sel_last = in_last[w_sel];
  assign w_sel_inc  = (w_sel == SRC_W'(NUM_SRC - 1)) ? {SRC_W{1'b0}} : (w_sel + SRC_W'(1));
  assign in_ready   = w_ready & {NUM_SRC{rst_n}};
  assign w_xfer     = |(in_valid & in_ready);

  // Round-robin search: scanning downward lets the source nearest rr_ptr win.
  always_comb begin
    w_found = 1'b0;
    w_pick  = {SRC_W{1'b0}};
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_pick  = in_valid[wrap_idx(int'(r_rr_ptr), k)] ? wrap_idx(int'(r_rr_ptr), k) : w_pick;
      w_found = w_found | in_valid[wrap_idx(int'(r_rr_ptr), k)];
    end
  end

  // Per-source ready: the round-robin winner in IDLE, only the owner in LOCK.
  always_comb begin
    w_ready = {NUM_SRC{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (w_has_cred && w_found) begin
          w_ready[w_pick] = 1'b1;
        end else begin
          w_ready = {NUM_SRC{1'b0}};
        end
      end
      ST_LOCK: begin
        w_ready[r_owner] = w_has_cred;
      end
      default: begin
        w_ready = {NUM_SRC{1'b0}};
      end
    endcase
  end

  // Next state, owner and pointer; nothing moves without a transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    if (w_xfer) begin
      if (w_sel_last) begin
        w_state_nxt = ST_IDLE;
        w_rr_nxt    = w_sel_inc;
      end else begin
        w_state_nxt = ST_LOCK;
        w_owner_nxt = w_sel;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state, packet owner and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_owner  <= {SRC_W{1'b0}};
      r_rr_ptr <= {SRC_W{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Credit pool; a return into a full pool is dropped and flagged sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cred     <= 4'(MAX_CRED);
      r_cred_err <= 1'b0;
    end else begin
      case ({w_xfer, cred_return})
        2'b10: r_cred <= r_cred - 4'd1;
        2'b01: begin
          if (r_cred == 4'(MAX_CRED)) begin
            r_cred_err <= 1'b1;
          end else begin
            r_cred <= r_cred + 4'd1;
          end
        end
        default: r_cred <= r_cred;
      endcase
    end
  end

  // Output beat register, one cycle behind the accepting handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= {DATA_W{1'b0}};
      r_out_src   <= {SRC_W{1'b0}};
    end else begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_last <= w_sel_last;
        r_out_data <= in_data[int'(w_sel) * DATA_W +: DATA_W];
        r_out_src  <= w_sel;
      end else begin
        r_out_last <= r_out_last;
        r_out_data <= r_out_data;
        r_out_src  <= r_out_src;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign out_data   = r_out_data;
  assign out_src    = r_out_src;
  assign cred_avail = r_cred;
  assign cred_err   = r_cred_err;

endmodule
